serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 126 ++++++++++++
 tb/tb_serial_adder.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//   Bit-serial adder: computes A+B one bit per clock, LSB first, with a single
//   1-bit full adder and a 1-bit carry register.  Three-state control FSM
//   (IDLE -> ADD for WIDTH cycles -> DONE for one cycle -> IDLE).
//
// Ports
//   clk    in   1      clock, all state changes on rising edge
//   reset  in   1      synchronous active-high reset, priority over start
//   start  in   1      begin an addition (accepted only in IDLE)
//   A, B   in   WIDTH  operands, captured on an accepted start
//   busy   out  1      high while in ADD
//   done   out  1      one-cycle pulse when S/C take a new result
//   S      out  WIDTH  sum of last completed addition (mod 2^WIDTH)
//   C      out  1      carry-out of last completed addition
// -----------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             C
);

    // Counter holds values 0..WIDTH, so one bit beyond $clog2(WIDTH).
    localparam int             CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             sum_bit;
    logic             carry_next;
    logic             last_bit;

    // Full adder built from two half adders plus an OR; returns {cout, sum}.
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic cin);
        logic s1, c1, s2, c2;
        s1 = a ^ b;
        c1 = a & b;
        s2 = s1 ^ cin;
        c2 = s1 & cin;
        return {c1 | c2, s2};
    endfunction

    assign {carry_next, sum_bit} = full_add(a_sh[0], b_sh[0], carry);
    assign last_bit = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = ADD;
            end
            ADD: begin
                busy = 1'b1;
                if (last_bit) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            S      <= '0;
            C      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= A;
                        b_sh  <= B;
                        carry <= 1'b0;
                        cnt   <= '0;
                    end
                end
                ADD: begin
                    // Sum bits enter at the MSB so after WIDTH shifts bit 0 is the LSB.
                    res_sh <= {sum_bit, res_sh[WIDTH-1:1]};
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    carry  <= carry_next;
                    cnt    <= cnt + CW'(1);
                    if (last_bit) begin
                        S <= {sum_bit, res_sh[WIDTH-1:1]};
                        C <= carry_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         busy;
    logic         done;
    logic [W-1:0] S;
    logic         C;

    int checks   = 0;
    int failures = 0;

    logic [W:0] exp_q[$];   // {C, S}

    serial_adder #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start),
        .A(A), .B(B), .busy(busy), .done(done), .S(S), .C(C)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Scoreboard monitor: every done pulse pops one expected result.
    always @(negedge clk) begin
        if (busy && done) check("busy_and_done", 1, 0);
        if (done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                logic [W:0] e;
                e = exp_q.pop_front();
                check("result_S", {24'd0, S}, {24'd0, e[W-1:0]});
                check("result_C", {31'd0, C}, {31'd0, e[W]});
            end
        end
    end

    // Pulse start across one rising edge; returns at the following negedge.
    task automatic do_start(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start = 1'b1; A = a; B = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] s, input logic c);
        exp_q.push_back({c, s});
        do_start(a, b);
    endtask

    // Wait for done (bounded), counting busy cycles and checking S/C stay put.
    // Operands are scrambled during ADD; they must not matter.
    task automatic wait_done(input string name, input logic [W-1:0] prev_s, input logic prev_c,
                             input bit inject_start);
        int nbusy = 0;
        int i;
        bit seen = 0;
        for (i = 0; i < 50; i++) begin
            if (done) begin
                seen = 1;
                break;
            end
            if (busy) begin
                nbusy++;
                if (S !== prev_s || C !== prev_c) check({name, "_hold"}, {23'd0, C, S}, {23'd0, prev_c, prev_s});
            end
            A = W'($urandom);
            B = W'($urandom);
            start = (inject_start && nbusy == 3);
            if (inject_start && nbusy == 3) begin
                A = 8'h01; B = 8'h01;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check({name, "_done_seen"}, {31'd0, seen}, 1);
        check({name, "_busy_cycles"}, nbusy, W);
        @(negedge clk);
        check({name, "_done_one_cycle"}, {31'd0, done}, 0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; A = '0; B = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("reset_busy", {31'd0, busy}, 0);
        check("reset_done", {31'd0, done}, 0);
        check("reset_S", {24'd0, S}, 0);
        check("reset_C", {31'd0, C}, 0);

        // Zero operands, latency and busy length
        issue(8'h00, 8'h00, 8'h00, 1'b0);
        check("zero_busy_after_start", {31'd0, busy}, 1);
        wait_done("zero", 8'h00, 1'b0, 0);

        issue(8'h05, 8'h03, 8'h08, 1'b0);
        wait_done("add5_3", 8'h00, 1'b0, 0);

        // Full ripple carry
        issue(8'hFF, 8'h01, 8'h00, 1'b1);
        wait_done("ripple", 8'h08, 1'b0, 0);

        // Start during ADD is ignored
        issue(8'hFF, 8'hFF, 8'hFE, 1'b1);
        wait_done("ignore_start", 8'h00, 1'b1, 1);
        issue(8'h01, 8'h01, 8'h02, 1'b0);
        wait_done("fresh_start", 8'hFE, 1'b1, 0);

        // Reset mid-ADD aborts with no done pulse
        do_start(8'hAA, 8'h55);
        repeat (3) @(negedge clk);
        check("abort_busy_before", {31'd0, busy}, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", {31'd0, busy}, 0);
        check("abort_done", {31'd0, done}, 0);
        check("abort_S", {24'd0, S}, 0);
        check("abort_C", {31'd0, C}, 0);
        repeat (12) @(negedge clk);
        check("abort_idle", {30'd0, busy, done}, 0);
        issue(8'h80, 8'h80, 8'h00, 1'b1);
        wait_done("after_abort", 8'h00, 1'b0, 0);

        // Reset wins over start on the same edge
        @(negedge clk);
        reset = 1'b1; start = 1'b1; A = 8'h12; B = 8'h34;
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        check("rst_start_busy", {31'd0, busy}, 0);
        check("rst_start_done", {31'd0, done}, 0);
        check("rst_start_S", {24'd0, S}, 0);
        repeat (12) @(negedge clk);
        check("rst_start_idle", {30'd0, busy, done}, 0);

        check("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
